// File: rtl/ysyx_22040088_ifu.sv
// ysyx_22040088_ifu: instruction fetch unit with a request/response imem port.
// Optional trap on misaligned targets: define YSYX_22040088_IFU_MISALIGN_EN.
module ysyx_22040088_ifu #(
  parameter logic [63:0] RESET_PC = 64'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] nextpc,
  input  logic        pc_we,
  output logic [63:0] pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_EXEC = 3'd3
`ifdef YSYX_22040088_IFU_MISALIGN_EN
    ,
    S_TRAP = 3'd4
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        accept;

`ifdef YSYX_22040088_IFU_MISALIGN_EN
  logic        misalign_q, misalign_d;
`endif

  // pc_we only counts once the held instruction has been handed off
  assign accept = pc_we &&
                  ((state_q == S_EXEC) ||
                   ((state_q == S_HOLD) && inst_ready));

  // next-state, PC update and response capture
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
`ifdef YSYX_22040088_IFU_MISALIGN_EN
    misalign_d = misalign_q;
`endif
    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d    = imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) state_d = pc_we ? S_REQ : S_EXEC;
      end
      S_EXEC: begin
        if (pc_we) state_d = S_REQ;
      end
`ifdef YSYX_22040088_IFU_MISALIGN_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: state_d = S_REQ;
    endcase
    if (accept) begin
`ifdef YSYX_22040088_IFU_MISALIGN_EN
      if (nextpc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = S_TRAP;
      end else begin
        pc_d = nextpc;
      end
`else
      pc_d = nextpc & ~64'h3;
`endif
    end
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 64'h0;
`ifdef YSYX_22040088_IFU_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
`ifdef YSYX_22040088_IFU_MISALIGN_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // handshakes are masked while rst is held so nothing leaks out
  assign imem_req_valid = !rst && (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = !rst && (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc             = pc_q;
`ifdef YSYX_22040088_IFU_MISALIGN_EN
  assign misalign       = misalign_q;
`else
  assign misalign       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// tb_ysyx_22040088_ifu: directed + random check of the fetch unit
// against a transaction-level reference model.
module tb_ysyx_22040088_ifu;

  localparam logic [63:0] RST_PC = 64'h80000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] nextpc;
  logic        pc_we;
  logic [63:0] pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        misalign;

  always #5 clk = ~clk;

  ysyx_22040088_ifu #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .nextpc          (nextpc),
    .pc_we           (pc_we),
    .pc              (pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .misalign        (misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: what the fetch unit is doing in transaction terms
  localparam int P_FETCH  = 0;
  localparam int P_MEM    = 1;
  localparam int P_DECODE = 2;
  localparam int P_COMMIT = 3;
  localparam int P_TRAP   = 4;

  int          ph;
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [63:0] m_inst_pc;
  logic        m_mis;

  task automatic model_commit();
`ifdef YSYX_22040088_IFU_MISALIGN_EN
    if ((nextpc % 4) != 0) begin
      m_mis = 1'b1;
      ph    = P_TRAP;
    end else begin
      m_pc = nextpc;
    end
`else
    m_pc = nextpc - (nextpc % 4);
`endif
  endtask

  task automatic model_step();
    if (rst) begin
      ph = P_FETCH; m_pc = RST_PC; m_inst = 0; m_inst_pc = 0; m_mis = 0;
    end else begin
      case (ph)
        P_FETCH: if (imem_req_ready) ph = P_MEM;
        P_MEM: if (imem_resp_valid) begin
          m_inst = imem_resp_data; m_inst_pc = m_pc; ph = P_DECODE;
        end
        P_DECODE: if (inst_ready) begin
          ph = pc_we ? P_FETCH : P_COMMIT;
          if (pc_we) model_commit();
        end
        P_COMMIT: if (pc_we) begin
          ph = P_FETCH;
          model_commit();
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic ev;
    ev = !rst && ph == P_FETCH;
    check("req_valid", 64'(imem_req_valid), 64'(ev));
    if (ev) check("req_addr", imem_req_addr, m_pc);
    check("pc", pc, m_pc);
    check("inst_valid", 64'(inst_valid), 64'(!rst && ph == P_DECODE));
    check("inst", 64'(inst), 64'(m_inst));
    check("inst_pc", inst_pc, m_inst_pc);
    check("misalign", 64'(misalign), 64'(m_mis));
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] d, input logic ir,
                       input logic we, input logic [63:0] npc);
    rst = r; imem_req_ready = rdy; imem_resp_valid = rv;
    imem_resp_data = d; inst_ready = ir; pc_we = we; nextpc = npc;
  endtask

  task automatic step();
    #3 compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [63:0] hold_pc;
    logic [31:0] hold_inst;
    drive(1, 1, 0, 0, 0, 0, 0);
    @(posedge clk); model_step(); #1;
    step();

    // reset release: request at RESET_PC right away
    drive(0, 1, 0, 0, 0, 0, 0);
    #1 check("rel_valid", 64'(imem_req_valid), 64'd1);
    check("rel_addr", imem_req_addr, 64'h80000000);
    step();
    drive(0, 0, 1, 32'h00000013, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 1, 64'h80000004);
    #1 check("first_inst", 64'(inst), 64'h13);
    check("first_inst_pc", inst_pc, 64'h80000000);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check("next_addr", imem_req_addr, 64'h80000004);
    check("next_valid", 64'(imem_req_valid), 64'd1);

    // decode stall: instruction held five cycles
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 32'hdeadbeef, 0, 0, 0); step();
    hold_inst = inst; hold_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 32'h0, 0, 1'(i & 1), 64'h90000000);
      step();
    end
    check("hold_inst", 64'(inst), 64'(hold_inst));
    check("hold_pc", inst_pc, hold_pc);
    check("hold_valid", 64'(inst_valid), 64'd1);
    drive(0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 64'h80000010); step();

    // stray response and stray pc_we are ignored
    drive(0, 0, 1, 32'h1111, 0, 0, 0); step();
    drive(0, 1, 1, 32'h2222, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 64'h80000100); step();
    check("stray_pc", pc, 64'h80000010);
    drive(0, 0, 1, 32'h3333, 0, 0, 0); step();
    check("resp_inst", 64'(inst), 64'h3333);

    // misaligned target
    drive(0, 0, 0, 0, 1, 1, 64'h80000006); step();
    drive(0, 1, 0, 0, 0, 0, 0);
`ifdef YSYX_22040088_IFU_MISALIGN_EN
    #1 check("mis_flag", 64'(misalign), 64'd1);
    check("mis_noreq", 64'(imem_req_valid), 64'd0);
    step(); step();
    check("mis_noreq2", 64'(imem_req_valid), 64'd0);
    drive(1, 0, 0, 0, 0, 0, 0); step();
`else
    #1 check("mis_addr", imem_req_addr, 64'h80000004);
    check("mis_flag", 64'(misalign), 64'd0);
    step();
`endif

    // reset while a request is outstanding
    drive(0, 1, 0, 0, 0, 0, 0); step();
    drive(1, 0, 1, 32'hbad0bad0, 1, 1, 64'h80000200); step();
    drive(0, 0, 0, 0, 1, 0, 0);
    #1 check("rst_pc", pc, 64'h80000000);
    check("rst_noinst", 64'(inst_valid), 64'd0);
    check("rst_req", 64'(imem_req_valid), 64'd1);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] npc;
      npc = RST_PC + 64'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 9) == 0) npc = npc + 64'($urandom_range(1, 3));
      drive($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom),
            $urandom, 1'($urandom), 1'($urandom), npc);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_ifu.md
YSYX_22040088_IFU -- requirements
Module: ysyx_22040088_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h80000000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port nextpc, input, 64, the next PC from the next-PC select logic.
REQ-005 SHALL have port pc_we, input, 1, commit strobe that loads nextpc into PC.
REQ-006 SHALL have port pc, output, 64, the current PC register.
REQ-007 SHALL have ports imem_req_valid (output, 1), imem_req_addr (output, 64) and imem_req_ready (input, 1), forming the fetch request channel.
REQ-008 SHALL have ports imem_resp_valid (input, 1) and imem_resp_data (input, 32), forming the fetch response channel; it has no backpressure.
REQ-009 SHALL have ports inst_valid (output, 1), inst (output, 32), inst_pc (output, 64) and inst_ready (input, 1), forming the decode channel.
REQ-010 SHALL have port misalign, output, 1, a sticky misaligned-target flag.

Function
REQ-011 SHALL implement a four-state FSM with states S_REQ, S_WAIT, S_HOLD and S_EXEC.
REQ-012 SHALL, in S_REQ, drive imem_req_valid=1 and imem_req_addr=pc, and move to S_WAIT on imem_req_ready; imem_req_valid=0 in all other states.
REQ-013 SHALL ignore imem_resp_valid outside S_WAIT, including a response in the same cycle as the request handshake.
REQ-014 SHALL, in S_WAIT on imem_resp_valid, register imem_resp_data into inst, set inst_pc=pc and move to S_HOLD; inst_valid is 1 only in S_HOLD.
REQ-015 SHALL keep inst and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-016 SHALL, in S_HOLD on inst_ready, go to S_REQ if pc_we=1 in that same cycle, otherwise go to S_EXEC.
REQ-017 SHALL, in S_EXEC, wait for pc_we and then go to S_REQ.
REQ-018 SHALL load PC<=nextpc on pc_we only in S_EXEC, or in S_HOLD together with inst_ready; pc_we in any other case is ignored.
REQ-019 SHALL reach latency pc_we at cycle N -> imem_req_valid=1 with the new address at cycle N+1.
REQ-020 SHALL reach best-case throughput of one instruction per 3 cycles: request, response, hand-off with pc_we.

Reset
REQ-021 SHALL, while rst=1, set pc=RESET_PC, state=S_REQ, inst=0, inst_pc=0 and misalign=0; as a result imem_req_valid=0 and inst_valid=0 during reset.
REQ-022 SHALL abandon any state on reset mid-operation, including an outstanding request; the memory is reset by the same rst.
REQ-023 SHALL raise imem_req_valid=1 with imem_req_addr=RESET_PC in the first cycle after rst falls.

Configuration
REQ-024 SHALL, when YSYX_22040088_IFU_MISALIGN_EN is defined, on an accepted pc_we with nextpc[1:0]!=0, leave pc unchanged, set misalign=1 and enter a fifth state S_TRAP that issues no requests until reset.
REQ-025 SHALL, when YSYX_22040088_IFU_MISALIGN_EN is undefined, load {nextpc[63:2],2'b00}, tie misalign to 0 and omit S_TRAP.

Verification
REQ-026 SHALL cover reset release with imem_req_ready=1 -> the next cycle has imem_req_valid=1 and imem_req_addr=64'h80000000.
REQ-027 SHALL cover a response of data 32'h00000013 one cycle after the request, then inst_ready=1 with pc_we=1 and nextpc=64'h80000004 -> inst=32'h00000013, inst_pc=64'h80000000, next request addr=64'h80000004.
REQ-028 SHALL cover holding inst_ready=0 for 5 cycles -> inst_valid held at 1, inst and inst_pc constant, no new request.
REQ-029 SHALL cover imem_resp_valid pulsed during S_REQ, and pc_we pulsed during S_WAIT -> both ignored, with pc unchanged.
REQ-030 SHALL cover nextpc=64'h80000006 on an accepted pc_we -> with the macro, misalign=1 and no further requests; without it, next addr=64'h80000004.
REQ-031 SHALL cover rst asserted in S_WAIT -> after release, pc=64'h80000000, no stale instruction delivered, and a new request issued.
